// File: rtl/eth_tx_arbiter_n.sv
// N-port GMII transmit arbiter: whole-frame grants, registered byte mux,
// forced inter-frame gap and a stuck-grant watchdog.
module eth_tx_arbiter_n #(
  parameter int NUM_PORTS      = 4,
  parameter int RR_MODE        = 1,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         port_req,
  input  logic [NUM_PORTS-1:0]         port_done,
  input  logic [NUM_PORTS-1:0]         port_tx_en,
  input  logic [8*NUM_PORTS-1:0]       port_txd,
  output logic [NUM_PORTS-1:0]         port_sel,
  output logic                         gmii_tx_en,
  output logic [7:0]                   gmii_txd,
  output logic [$clog2(NUM_PORTS)-1:0] owner_idx,
  output logic                         busy,
  output logic                         timeout_pulse
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IFG_W-1:0] IFG_MAX  = IFG_W'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_IFG
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] sel_q, sel_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [IFG_W-1:0]     ifg_q, ifg_d;
  logic                 tx_en_q, tx_en_d;
  logic [7:0]           txd_q, txd_d;
  logic                 to_q, to_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;

  // Rotating search: round-robin starts at rr_q, fixed priority at 0.
  always_comb begin : arb
    int               s;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;
    base      = (RR_MODE != 0) ? rr_q : '0;
    s         = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      s = int'(base) + i;
      if (s >= NUM_PORTS) begin
        s = s - NUM_PORTS;
      end
      cand = IDX_W'(s);
      if (!win_found && port_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    ifg_d   = ifg_q;
    to_d    = 1'b0;
    tx_en_d = (state_q == S_GRANT) && port_tx_en[owner_q];
    txd_d   = tx_en_d ? port_txd[{owner_q, 3'b000} +: 8] : 8'h00;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          sel_d   = NUM_PORTS'(1) << win_idx;
          owner_d = win_idx;
          wd_d    = '0;
          if (RR_MODE != 0) begin
            rr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          end
        end
      end
      S_GRANT: begin
        // A real end-of-frame wins over a watchdog expiry in the same cycle.
        if (port_done[owner_q]) begin
          state_d = S_IFG;
          sel_d   = '0;
          ifg_d   = '0;
        end else if (wd_q == WD_MAX) begin
          state_d = S_IFG;
          sel_d   = '0;
          ifg_d   = '0;
          to_d    = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_IFG: begin
        if (ifg_q == IFG_MAX) begin
          state_d = S_IDLE;
        end else begin
          ifg_d = ifg_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
      ifg_q   <= '0;
      tx_en_q <= 1'b0;
      txd_q   <= 8'h00;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      ifg_q   <= ifg_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
      to_q    <= to_d;
    end
  end

  assign port_sel      = sel_q;
  assign owner_idx     = owner_q;
  assign gmii_tx_en    = tx_en_q;
  assign gmii_txd      = txd_q;
  assign timeout_pulse = to_q;
  assign busy          = (state_q != S_IDLE);

endmodule
